udp_reg_frame_rx: RTL and testbench
===================================

# udp_reg_frame_rx

Parametrised register-write frame receiver. It sits after the rx MAC FIFO and consumes raw Ethernet frames as an 8-bit AXI-stream. Each frame is checked for a sync word and carries a header that selects a base register. Payload bytes are staged and committed to the register file atomically, and only if the frame is good. Byte-granular write masking, per-register write strobes, and good/bad frame counters are provided.

## Interface
Parameters:
- NREGS, 16: number of 32-bit registers (2..256).
- HDR_SKIP, 14: leading MAC header bytes discarded.
- SYNC0, 8'hF3: first sync byte.
- SYNC1, 8'hFA: second sync byte.
- CNT_W, 16: width of the frame counters.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- rx_tvalid  in  1  stream byte valid.
- rx_tready  out  1  0 while rstn=0, otherwise 1; no backpressure.
- rx_tdata  in  8  stream byte.
- rx_tlast  in  1  last byte of frame.
- rx_tuser  in  1  frame error flag; sampled on the tlast beat only.
- dv_out  out  1  one-cycle pulse when wr_val is updated.
- wr_val  out  NREGS×32  register file.
- wr_strb  out  NREGS  registers touched by the commit; nonzero only while dv_out=1.
- ovf  out  1  qualified by dv_out; the committed frame had payload beyond register NREGS-1.
- good_cnt  out  CNT_W  committed frames, saturating.
- bad_cnt  out  CNT_W  discarded frames, saturating.

## Operation
- Frame layout:
  - HDR_SKIP bytes, ignored.
  - SYNC0, SYNC1.
  - 4-byte header: byte0 = base register index B; bytes 1..3 reserved, ignored.
  - Payload: payload byte k targets register B + k/4, bit lane (k%4)*8.
- A beat is accepted when rx_tvalid & rx_tready.
- States:
  - SKIP: count HDR_SKIP beats, then go to SYNC.
  - SYNC: first beat must equal SYNC0 and second must equal SYNC1. A mismatch goes to DROP.
  - HDR: 4 beats; B is latched from byte0.
  - DATA: payload beats.
  - DROP: wait for tlast.
- A beat with tlast returns the FSM to SKIP after that beat, in every state.
- Staging:
  - Staging byte array of NREGS×4 bytes plus a byte-valid mask.
  - In DATA, a byte whose target index is below NREGS×4 is written to staging and its mask bit is set.
  - A byte whose target is out of range is dropped and sets the internal ovf flag.
- Byte index arithmetic is done at ⌈log2(NREGS×4)⌉+10 bits so that it cannot wrap. A B value ≥ NREGS makes all payload out of range.
- tlast handling:
  - Good frame: tlast in DATA with tuser=0, or tlast on the 4th HDR beat with tuser=0.
    - For every set mask bit, that byte of wr_val takes the staging value. Unmasked bytes keep their old value.
    - wr_strb[i] = OR of register i's 4 mask bits.
    - dv_out=1, ovf = internal flag, good_cnt+1.
  - Bad frame: tlast in SKIP, SYNC, HDR before its 4th beat, or DROP; or tuser=1 in any state.
    - No change to wr_val, dv_out stays 0, bad_cnt+1.
  - In both cases the mask and internal ovf are cleared.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Gaps (rx_tvalid=0) are allowed anywhere. State and staging hold during a gap.

## Timing
- Reset values: rx_tready=0, dv_out=0, wr_strb=0, ovf=0, wr_val=0, good_cnt=0, bad_cnt=0. The FSM resets to SKIP and the mask to 0.
- Latency: tlast accepted at edge T; wr_val, wr_strb, ovf, dv_out and the counters update at edge T+1. dv_out is high for exactly one cycle.
- Back-to-back frames with zero idle cycles are supported. The first byte of the next frame may be accepted at edge T+1 and lands in SKIP. The mask clear at T+1 does not lose any next-frame data.
- Reset mid-frame:
  - The partial frame is discarded; no commit and no counter change.
  - The FSM resumes in SKIP. The remainder of the interrupted frame is treated as a new frame and is normally rejected by the sync check.
- Payload bytes that are rewritten within one frame: the last write wins.

## Test plan
- Good frame, B=2, payload 01..08 → at T+1: wr_val[2]=0x04030201, wr_val[3]=0x08070605, wr_strb=0x000C, dv_out high 1 cycle, good_cnt=1, ovf=0; all other registers are 0.
- Follow-up frame B=3 with 2-byte payload AA,BB → wr_val[3]=0x0807BBAA, wr_strb=0x0008, good_cnt=2.
- Sync bytes F3,00 followed by 10 bytes then tlast → no dv_out, wr_val unchanged, bad_cnt=1. The next good frame sent with zero gap commits normally.
- Good-layout frame with rx_tuser=1 on the tlast beat → discarded, bad_cnt+1. A runt frame ending at byte 10 → bad_cnt+1.
- NREGS=16, B=15, 8-byte payload 11..18 → wr_val[15]=0x14131211, wr_strb=0x8000, ovf=1. B=20 → wr_strb=0, ovf=1, dv_out=1, good_cnt+1.
- rstn pulsed low mid-payload, then the bench drives the preload sequence below:
  - During reset: rx_tready=0, all outputs 0.
  - Preload good_cnt to 2^CNT_W−1 with CNT_W=4 by sending 20 good frames → good_cnt holds at 15.

Source files
------------

// File: rtl/udp_reg_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : udp_reg_frame_rx
// Purpose  : Register-write frame receiver. Consumes raw Ethernet frames as an
//            8-bit AXI-stream, strips the MAC header, checks a two-byte sync
//            word, latches a base register index from a 4-byte header, stages
//            payload bytes and commits them to the register file atomically
//            only when the frame ends cleanly.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1          single clock, rising edge
//   rstn       in   1          asynchronous active-low reset
//   rx_tvalid  in   1          stream byte valid
//   rx_tready  out  1          low in reset, otherwise high (no backpressure)
//   rx_tdata   in   8          stream byte
//   rx_tlast   in   1          last byte of frame
//   rx_tuser   in   1          frame error flag, sampled on the tlast beat
//   dv_out     out  1          one-cycle pulse when wr_val is updated
//   wr_val     out  NREGS*32   register file (register i at [i*32 +: 32])
//   wr_strb    out  NREGS      registers touched by the commit
//   ovf        out  1          committed frame ran past register NREGS-1
//   good_cnt   out  CNT_W      committed frames, saturating
//   bad_cnt    out  CNT_W      discarded frames, saturating
// ============================================================================
module udp_reg_frame_rx #(
    parameter int         NREGS    = 16,
    parameter int         HDR_SKIP = 14,
    parameter logic [7:0] SYNC0    = 8'hF3,
    parameter logic [7:0] SYNC1    = 8'hFA,
    parameter int         CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_tvalid,
    output logic                  rx_tready,
    input  logic [7:0]            rx_tdata,
    input  logic                  rx_tlast,
    input  logic                  rx_tuser,
    output logic                  dv_out,
    output logic [NREGS*32-1:0]   wr_val,
    output logic [NREGS-1:0]      wr_strb,
    output logic                  ovf,
    output logic [CNT_W-1:0]      good_cnt,
    output logic [CNT_W-1:0]      bad_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_NB = NREGS * 4;           // staging bytes
    localparam int c_AW = $clog2(c_NB);        // staging byte address width
    // Ten spare bits: base*4 (< 1024) plus a saturating payload count can
    // never wrap back into the valid staging range.
    localparam int c_IW = c_AW + 10;
    // Beat counter wide enough for the MAC skip count and the 4 header beats.
    localparam int c_CW = $clog2(HDR_SKIP + 5);

    typedef enum logic [2:0] {
        S_SKIP = 3'd0,
        S_SYNC = 3'd1,
        S_HDR  = 3'd2,
        S_DATA = 3'd3,
        S_DROP = 3'd4
    } state_t;

    // With no MAC header to discard the frame starts directly at the sync word.
    localparam state_t c_START = (HDR_SKIP == 0) ? S_SYNC : S_SKIP;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [c_CW-1:0]       r_cnt;
    logic [7:0]            r_base;
    logic [c_IW-1:0]       r_pidx;
    logic [7:0]            r_stage [c_NB];
    logic [c_NB-1:0]       r_mask;
    logic                  r_ovf_int;
    logic                  r_commit;
    logic                  r_discard;

    logic                  r_dv;
    logic [NREGS*32-1:0]   r_wr_val;
    logic [NREGS-1:0]      r_strb;
    logic                  r_ovf;
    logic [CNT_W-1:0]      r_good;
    logic [CNT_W-1:0]      r_bad;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                  w_acc;
    logic [c_IW-1:0]       w_tgt;
    logic                  w_inrng;
    logic [c_AW-1:0]       w_tgt_idx;
    logic                  w_good_end;

    assign rx_tready = rstn;
    assign w_acc     = rx_tvalid & rstn;

    // Payload byte k targets staging byte base*4 + k.
    assign w_tgt     = {{(c_IW-10){1'b0}}, r_base, 2'b00} + r_pidx;
    assign w_inrng   = (w_tgt < c_IW'(c_NB));
    assign w_tgt_idx = w_tgt[c_AW-1:0];

    // A frame is good if it ends in DATA, or exactly on the last header beat
    // (an empty payload), with no error flag.
    assign w_good_end = !rx_tuser &&
                        ((r_state == S_DATA) ||
                         ((r_state == S_HDR) && (r_cnt == c_CW'(3))));

    // ------------------------------------------------------------------------
    // Staging byte storage. Only bytes whose mask bit is set are ever read,
    // so the data array itself needs no reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_acc && (r_state == S_DATA) && w_inrng) begin
            r_stage[w_tgt_idx] <= rx_tdata;
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM, staging mask, commit and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= c_START;
            r_cnt     <= '0;
            r_base    <= '0;
            r_pidx    <= '0;
            r_mask    <= '0;
            r_ovf_int <= 1'b0;
            r_commit  <= 1'b0;
            r_discard <= 1'b0;
            r_dv      <= 1'b0;
            r_wr_val  <= '0;
            r_strb    <= '0;
            r_ovf     <= 1'b0;
            r_good    <= '0;
            r_bad     <= '0;
        end else begin
            r_dv      <= 1'b0;
            r_strb    <= '0;
            r_ovf     <= 1'b0;
            r_commit  <= 1'b0;
            r_discard <= 1'b0;

            // ---- end-of-frame action, one cycle after the tlast beat ----
            if (r_commit) begin
                for (int i = 0; i < c_NB; i++) begin
                    if (r_mask[i]) begin
                        r_wr_val[i*8 +: 8] <= r_stage[i];
                    end
                end
                for (int r = 0; r < NREGS; r++) begin
                    r_strb[r] <= |r_mask[r*4 +: 4];
                end
                r_dv  <= 1'b1;
                r_ovf <= r_ovf_int;
                if (r_good != c_CNT_MAX) begin
                    r_good <= r_good + CNT_W'(1);
                end
            end

            if (r_discard && (r_bad != c_CNT_MAX)) begin
                r_bad <= r_bad + CNT_W'(1);
            end

            // The next frame is still in SKIP/SYNC here, so clearing the
            // mask cannot collide with a new payload write.
            if (r_commit || r_discard) begin
                r_mask    <= '0;
                r_ovf_int <= 1'b0;
            end

            // ---- beat processing ----
            if (w_acc) begin
                case (r_state)
                    S_SKIP: begin
                        if (r_cnt == c_CW'(HDR_SKIP - 1)) begin
                            r_state <= S_SYNC;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt   <= r_cnt + c_CW'(1);
                        end
                    end
                    S_SYNC: begin
                        if (r_cnt == '0) begin
                            if (rx_tdata == SYNC0) begin
                                r_cnt   <= c_CW'(1);
                            end else begin
                                r_state <= S_DROP;
                            end
                        end else begin
                            r_cnt <= '0;
                            if (rx_tdata == SYNC1) begin
                                r_state <= S_HDR;
                            end else begin
                                r_state <= S_DROP;
                            end
                        end
                    end
                    S_HDR: begin
                        if (r_cnt == '0) begin
                            r_base <= rx_tdata;
                        end
                        if (r_cnt == c_CW'(3)) begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                            r_pidx  <= '0;
                        end else begin
                            r_cnt   <= r_cnt + c_CW'(1);
                        end
                    end
                    S_DATA: begin
                        if (w_inrng) begin
                            r_mask[w_tgt_idx] <= 1'b1;
                        end else begin
                            r_ovf_int <= 1'b1;
                        end
                        // Saturate well above any valid index so an
                        // arbitrarily long payload stays out of range.
                        if (!r_pidx[c_IW-1]) begin
                            r_pidx <= r_pidx + c_IW'(1);
                        end
                    end
                    S_DROP: begin
                        r_cnt <= '0;
                    end
                    default: begin
                        r_state <= c_START;
                        r_cnt   <= '0;
                    end
                endcase

                // tlast ends the frame from any state; it overrides the
                // state/counter updates made above.
                if (rx_tlast) begin
                    r_state <= c_START;
                    r_cnt   <= '0;
                    if (w_good_end) begin
                        r_commit  <= 1'b1;
                    end else begin
                        r_discard <= 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign dv_out   = r_dv;
    assign wr_val   = r_wr_val;
    assign wr_strb  = r_strb;
    assign ovf      = r_ovf;
    assign good_cnt = r_good;
    assign bad_cnt  = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_udp_reg_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_reg_frame_rx
// Purpose  : Directed self-checking bench for udp_reg_frame_rx (NREGS=16,
//            HDR_SKIP=14, CNT_W=4 so counter saturation is reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_reg_frame_rx;

    localparam int NREGS = 16;
    localparam int CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 rx_tvalid = 1'b0;
    logic                 rx_tready;
    logic [7:0]           rx_tdata = 8'h00;
    logic                 rx_tlast = 1'b0;
    logic                 rx_tuser = 1'b0;
    logic                 dv_out;
    logic [NREGS*32-1:0]  wr_val;
    logic [NREGS-1:0]     wr_strb;
    logic                 ovf;
    logic [CNT_W-1:0]     good_cnt;
    logic [CNT_W-1:0]     bad_cnt;

    always #5 clk = ~clk;

    udp_reg_frame_rx #(
        .NREGS    (NREGS),
        .HDR_SKIP (14),
        .SYNC0    (8'hF3),
        .SYNC1    (8'hFA),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_tvalid (rx_tvalid),
        .rx_tready (rx_tready),
        .rx_tdata  (rx_tdata),
        .rx_tlast  (rx_tlast),
        .rx_tuser  (rx_tuser),
        .dv_out    (dv_out),
        .wr_val    (wr_val),
        .wr_strb   (wr_strb),
        .ovf       (ovf),
        .good_cnt  (good_cnt),
        .bad_cnt   (bad_cnt)
    );

    int checks = 0;
    int errors = 0;

    // dv_out pulse monitor: counts pulses, remembers the strobe/ovf seen with
    // the latest pulse, and counts pulses longer than one cycle.
    int               dv_cnt  = 0;
    int               dv_dbl  = 0;
    logic             dv_prev = 1'b0;
    logic [NREGS-1:0] last_strb = '0;
    logic             last_ovf  = 1'b0;

    always @(negedge clk) begin
        if (dv_out === 1'b1) begin
            dv_cnt++;
            last_strb = wr_strb;
            last_ovf  = ovf;
            if (dv_prev === 1'b1) dv_dbl++;
        end
        dv_prev = dv_out;
    end

    // Hand-maintained expected register file contents.
    logic [31:0] exp_regs [NREGS];

    // Frame build buffer.
    logic [7:0] frm [0:255];
    int         flen;

    function automatic logic [31:0] reg32(input int i);
        return wr_val[i*32 +: 32];
    endfunction

    function automatic int first_reg_mismatch();
        for (int i = 0; i < NREGS; i++) begin
            if (reg32(i) !== exp_regs[i]) return i;
        end
        return -1;
    endfunction

    task automatic push(input logic [7:0] d);
        frm[flen] = d;
        flen++;
    endtask

    // MAC header (14 non-zero filler bytes), sync word, header with base B.
    task automatic build_hdr(input logic [7:0] b);
        flen = 0;
        for (int i = 0; i < 14; i++) push(8'h40 + 8'(i));
        push(8'hF3);
        push(8'hFA);
        push(b);
        push(8'h5A);
        push(8'hA5);
        push(8'h3C);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input logic u);
        rx_tvalid = 1'b1;
        rx_tdata  = d;
        rx_tlast  = l;
        rx_tuser  = u;
        @(posedge clk);
        #1;
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        rx_tuser  = 1'b0;
    endtask

    task automatic send_frm(input logic u);
        for (int i = 0; i < flen; i++) begin
            send_byte(frm[i], (i == flen - 1), (i == flen - 1) ? u : 1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rstn = 1'b0;
        #12;
        checks++;
        if (rx_tready !== 1'b0 || dv_out !== 1'b0 || wr_strb !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: tready=%b dv=%b strb=%h ovf=%b, want 0/0/0/0",
                     rx_tready, dv_out, wr_strb, ovf);
        end
        checks++;
        if (wr_val !== '0 || good_cnt !== '0 || bad_cnt !== '0) begin
            errors++;
            $display("FAIL reset_data: wr_val=%h good=%0d bad=%0d, want all 0",
                     wr_val, good_cnt, bad_cnt);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        checks++;
        if (rx_tready !== 1'b1) begin
            errors++;
            $display("FAIL tready_after_reset: got %b want 1", rx_tready);
        end
        for (int i = 0; i < NREGS; i++) exp_regs[i] = 32'h0;
        idle(2);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_good_frame();
        int mm;
        build_hdr(8'd2);
        for (int k = 1; k <= 8; k++) push(8'(k));
        send_frm(1'b0);
        // T + 1ns: commit not yet visible
        checks++;
        if (dv_out !== 1'b0) begin
            errors++;
            $display("FAIL good_dv_at_T: got %b want 0", dv_out);
        end
        @(posedge clk);
        #1;
        exp_regs[2] = 32'h04030201;
        exp_regs[3] = 32'h08070605;
        checks++;
        if (dv_out !== 1'b1 || wr_strb !== 16'h000C || ovf !== 1'b0 || good_cnt !== 4'd1) begin
            errors++;
            $display("FAIL good_commit: dv=%b strb=%h ovf=%b good=%0d, want 1/000c/0/1",
                     dv_out, wr_strb, ovf, good_cnt);
        end
        mm = first_reg_mismatch();
        checks++;
        if (mm != -1) begin
            errors++;
            $display("FAIL good_regs: reg%0d=%h want %h", mm, reg32(mm), exp_regs[mm]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dv_out !== 1'b0 || wr_strb !== '0) begin
            errors++;
            $display("FAIL good_pulse_end: dv=%b strb=%h, want 0/0000", dv_out, wr_strb);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_followup();
        int mm;
        int dv0;
        dv0 = dv_cnt;
        build_hdr(8'd3);
        push(8'hAA);
        push(8'hBB);
        send_frm(1'b0);
        idle(2);
        exp_regs[3] = 32'h0807BBAA;
        checks++;
        if (dv_cnt - dv0 != 1 || last_strb !== 16'h0008 || good_cnt !== 4'd2) begin
            errors++;
            $display("FAIL followup: pulses=%0d strb=%h good=%0d, want 1/0008/2",
                     dv_cnt - dv0, last_strb, good_cnt);
        end
        mm = first_reg_mismatch();
        checks++;
        if (mm != -1) begin
            errors++;
            $display("FAIL followup_regs: reg%0d=%h want %h", mm, reg32(mm), exp_regs[mm]);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        int mm;
        int dv0;
        dv0 = dv_cnt;
        // Bad sync: F3,00 then 10 bytes, tlast on the 10th.
        flen = 0;
        for (int i = 0; i < 14; i++) push(8'h00);
        push(8'hF3);
        push(8'h00);
        for (int i = 0; i < 10; i++) push(8'h90 + 8'(i));
        send_frm(1'b0);
        // Next good frame with zero idle cycles.
        build_hdr(8'd0);
        push(8'hDE);
        push(8'hAD);
        push(8'hBE);
        push(8'hEF);
        send_frm(1'b0);
        idle(2);
        exp_regs[0] = 32'hEFBEADDE;
        checks++;
        if (bad_cnt !== 4'd1 || good_cnt !== 4'd3) begin
            errors++;
            $display("FAIL b2b_counts: bad=%0d good=%0d, want 1/3", bad_cnt, good_cnt);
        end
        checks++;
        if (dv_cnt - dv0 != 1 || last_strb !== 16'h0001) begin
            errors++;
            $display("FAIL b2b_commit: pulses=%0d strb=%h, want 1/0001", dv_cnt - dv0, last_strb);
        end
        mm = first_reg_mismatch();
        checks++;
        if (mm != -1) begin
            errors++;
            $display("FAIL b2b_regs: reg%0d=%h want %h", mm, reg32(mm), exp_regs[mm]);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_bad_frames();
        int mm;
        int dv0;
        dv0 = dv_cnt;
        build_hdr(8'd5);
        push(8'h77);
        push(8'h66);
        push(8'h55);
        push(8'h44);
        send_frm(1'b1);
        idle(2);
        checks++;
        if (bad_cnt !== 4'd2 || good_cnt !== 4'd3 || dv_cnt != dv0) begin
            errors++;
            $display("FAIL tuser_drop: bad=%0d good=%0d pulses=%0d, want 2/3/0",
                     bad_cnt, good_cnt, dv_cnt - dv0);
        end
        // Runt: ends at byte 10 while still in the MAC header.
        flen = 0;
        for (int i = 0; i < 10; i++) push(8'h20 + 8'(i));
        send_frm(1'b0);
        idle(2);
        checks++;
        if (bad_cnt !== 4'd3 || dv_cnt != dv0) begin
            errors++;
            $display("FAIL runt_drop: bad=%0d pulses=%0d, want 3/0", bad_cnt, dv_cnt - dv0);
        end
        mm = first_reg_mismatch();
        checks++;
        if (mm != -1) begin
            errors++;
            $display("FAIL bad_regs: reg%0d=%h want %h", mm, reg32(mm), exp_regs[mm]);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_overflow();
        int mm;
        int dv0;
        dv0 = dv_cnt;
        build_hdr(8'd15);
        for (int k = 0; k < 8; k++) push(8'h11 + 8'(k));
        send_frm(1'b0);
        idle(2);
        exp_regs[15] = 32'h14131211;
        checks++;
        if (dv_cnt - dv0 != 1 || last_strb !== 16'h8000 || last_ovf !== 1'b1 || good_cnt !== 4'd4) begin
            errors++;
            $display("FAIL ovf_edge: pulses=%0d strb=%h ovf=%b good=%0d, want 1/8000/1/4",
                     dv_cnt - dv0, last_strb, last_ovf, good_cnt);
        end
        dv0 = dv_cnt;
        build_hdr(8'd20);
        push(8'hC1);
        push(8'hC2);
        send_frm(1'b0);
        idle(2);
        checks++;
        if (dv_cnt - dv0 != 1 || last_strb !== 16'h0000 || last_ovf !== 1'b1 || good_cnt !== 4'd5) begin
            errors++;
            $display("FAIL ovf_base: pulses=%0d strb=%h ovf=%b good=%0d, want 1/0000/1/5",
                     dv_cnt - dv0, last_strb, last_ovf, good_cnt);
        end
        mm = first_reg_mismatch();
        checks++;
        if (mm != -1) begin
            errors++;
            $display("FAIL ovf_regs: reg%0d=%h want %h", mm, reg32(mm), exp_regs[mm]);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_and_saturate();
        int mm;
        int dv0;
        build_hdr(8'd1);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        for (int i = 0; i < flen; i++) send_byte(frm[i], 1'b0, 1'b0);
        rstn = 1'b0;
        #2;
        checks++;
        if (rx_tready !== 1'b0 || dv_out !== 1'b0 || wr_strb !== '0 || ovf !== 1'b0 ||
            wr_val !== '0 || good_cnt !== '0 || bad_cnt !== '0) begin
            errors++;
            $display("FAIL mid_reset: tready=%b dv=%b strb=%h ovf=%b good=%0d bad=%0d, want all 0",
                     rx_tready, dv_out, wr_strb, ovf, good_cnt, bad_cnt);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < NREGS; i++) exp_regs[i] = 32'h0;
        dv0 = dv_cnt;
        // Remainder of the interrupted frame: a short frame seen from SKIP.
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h06, 1'b0, 1'b0);
        send_byte(8'h07, 1'b1, 1'b0);
        idle(2);
        checks++;
        if (bad_cnt !== 4'd1 || good_cnt !== 4'd0 || dv_cnt != dv0) begin
            errors++;
            $display("FAIL remainder: bad=%0d good=%0d pulses=%0d, want 1/0/0",
                     bad_cnt, good_cnt, dv_cnt - dv0);
        end
        for (int f = 0; f < 20; f++) begin
            build_hdr(8'd0);
            push(8'(f + 1));
            send_frm(1'b0);
        end
        idle(2);
        exp_regs[0] = 32'h00000014;
        checks++;
        if (good_cnt !== 4'd15 || bad_cnt !== 4'd1 || dv_cnt - dv0 != 20) begin
            errors++;
            $display("FAIL saturate: good=%0d bad=%0d pulses=%0d, want 15/1/20",
                     good_cnt, bad_cnt, dv_cnt - dv0);
        end
        mm = first_reg_mismatch();
        checks++;
        if (mm != -1) begin
            errors++;
            $display("FAIL saturate_regs: reg%0d=%h want %h", mm, reg32(mm), exp_regs[mm]);
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        test_reset();
        test_good_frame();
        test_followup();
        test_back_to_back();
        test_bad_frames();
        test_overflow();
        test_reset_mid_and_saturate();
        checks++;
        if (dv_dbl != 0) begin
            errors++;
            $display("FAIL dv_width: %0d multi-cycle pulses, want 0", dv_dbl);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
